// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher
// Front-stage work source for a SHA-256d pipeline. Latches one mining job
// (midstate, header tail words, inclusive nonce range), then issues one nonce
// every ISSUE_PERIOD cycles. Each issue is a 1-cycle en_o strobe. The same
// cycle carries the nonce, the 16-word second-block message (w_in_o) and the
// job midstate (hin_o). The message layout is:
//   W0 merkle tail, W1 ntime, W2 nbits, W3 nonce, W4 pad bit, W5..W14 zero,
//   W15 message length.
//
// Ports
//   clk             clock, all logic on the rising edge
//   reset           synchronous, active-high
//   job_valid_i     job presented
//   job_ready_o     job can be accepted (idle only, low during reset)
//   job_midstate_i  H after the first header block, forwarded on hin_o
//   job_merkle_i    header word 16
//   job_time_i      header word 17
//   job_bits_i      header word 18
//   job_nstart_i    first nonce (inclusive)
//   job_nend_i      last nonce (inclusive), may be below nstart (wraps)
//   abort_i         cancel the running job
//   en_o            1-cycle issue strobe
//   nonce_o         nonce of the current/last issue
//   w_in_o          W[i] at bits [WORD_S*i +: WORD_S]
//   hin_o           midstate of the current job
//   busy_o          job in progress
//   done_o          1-cycle pulse: job finished or aborted
//   aborted_o       qualifies done_o: 1 = ended by abort
module nonce_dispatcher #(
  parameter int unsigned WORD_S       = 32,
  parameter int unsigned ISSUE_PERIOD = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [8*WORD_S-1:0]   job_midstate_i,
  input  logic [WORD_S-1:0]     job_merkle_i,
  input  logic [WORD_S-1:0]     job_time_i,
  input  logic [WORD_S-1:0]     job_bits_i,
  input  logic [WORD_S-1:0]     job_nstart_i,
  input  logic [WORD_S-1:0]     job_nend_i,
  input  logic                  abort_i,
  output logic                  en_o,
  output logic [WORD_S-1:0]     nonce_o,
  output logic [16*WORD_S-1:0]  w_in_o,
  output logic [8*WORD_S-1:0]   hin_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o
);

  // Wait counter spans ISSUE_PERIOD-2 down to 0. The ISSUE cycle plus the
  // WAIT cycles give exactly ISSUE_PERIOD cycles between strobes.
  localparam int unsigned CntW = (ISSUE_PERIOD > 2) ? $clog2(ISSUE_PERIOD) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(ISSUE_PERIOD - 2);

  // SHA-256 padding: a single 1 bit after the message, and the length in bits
  // of the 80-byte header (20 words) in the last word.
  localparam logic [WORD_S-1:0] PadWord = {1'b1, {(WORD_S - 1){1'b0}}};
  localparam logic [WORD_S-1:0] LenWord = WORD_S'(20 * WORD_S);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StFin
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WORD_S-1:0]   nend_q, nend_d;
  logic                ready_q, ready_d;
  logic                fin_abort_q, fin_abort_d;

  // Output-facing registers. They change only on the edge that enters ISSUE,
  // so each value appears together with en_o and holds until the next issue.
  logic [WORD_S-1:0]   nonce_q, nonce_d;
  logic [WORD_S-1:0]   merkle_q, merkle_d;
  logic [WORD_S-1:0]   time_q, time_d;
  logic [WORD_S-1:0]   bits_q, bits_d;
  logic [8*WORD_S-1:0] hin_q, hin_d;
  // Padding constants are gated so that w_in_o is all-zero out of reset.
  logic                pad_q, pad_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nend_d      = nend_q;
    fin_abort_d = fin_abort_q;
    nonce_d     = nonce_q;
    merkle_d    = merkle_q;
    time_d      = time_q;
    bits_d      = bits_q;
    hin_d       = hin_q;
    pad_d       = pad_q;

    unique case (state_q)
      StIdle: begin
        // ready_q is only high in IDLE outside reset, so it qualifies accept.
        if (job_valid_i && ready_q) begin
          state_d     = StIssue;
          nend_d      = job_nend_i;
          nonce_d     = job_nstart_i;
          merkle_d    = job_merkle_i;
          time_d      = job_time_i;
          bits_d      = job_bits_i;
          hin_d       = job_midstate_i;
          pad_d       = 1'b1;
          fin_abort_d = 1'b0;
        end
      end

      StIssue: begin
        cnt_d = CntReload;
        if (abort_i) begin
          // The strobe of this cycle stands; nothing further is issued.
          state_d     = StFin;
          fin_abort_d = 1'b1;
        end else if (nonce_q == nend_q) begin
          state_d     = StFin;
          fin_abort_d = 1'b0;
        end else begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (abort_i) begin
          state_d     = StFin;
          fin_abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = StIssue;
          // Advancing on entry to ISSUE keeps nonce_o stable between strobes.
          nonce_d = nonce_q + WORD_S'(1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered so that job_ready_o stays low while reset is held.
    ready_d = (state_d == StIdle);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      nend_q      <= '0;
      ready_q     <= 1'b0;
      fin_abort_q <= 1'b0;
      nonce_q     <= '0;
      merkle_q    <= '0;
      time_q      <= '0;
      bits_q      <= '0;
      hin_q       <= '0;
      pad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nend_q      <= nend_d;
      ready_q     <= ready_d;
      fin_abort_q <= fin_abort_d;
      nonce_q     <= nonce_d;
      merkle_q    <= merkle_d;
      time_q      <= time_d;
      bits_q      <= bits_d;
      hin_q       <= hin_d;
      pad_q       <= pad_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    en_o        = (state_q == StIssue);
    busy_o      = (state_q != StIdle);
    done_o      = (state_q == StFin);
    aborted_o   = (state_q == StFin) && fin_abort_q;
    job_ready_o = ready_q;
    nonce_o     = nonce_q;
    hin_o       = hin_q;
  end

  always_comb begin
    w_in_o                      = '0;
    w_in_o[0*WORD_S +: WORD_S]  = merkle_q;
    w_in_o[1*WORD_S +: WORD_S]  = time_q;
    w_in_o[2*WORD_S +: WORD_S]  = bits_q;
    w_in_o[3*WORD_S +: WORD_S]  = nonce_q;
    if (pad_q) begin
      w_in_o[4*WORD_S +: WORD_S]  = PadWord;
      w_in_o[15*WORD_S +: WORD_S] = LenWord;
    end
  end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// tb_nonce_dispatcher
// Self-checking bench for nonce_dispatcher. Jobs (directed and random) are run
// cycle by cycle. Each cycle is compared against an arithmetic model of the
// issue schedule. The k-th strobe of a job lands k*P cycles after the first
// one. Done follows the last strobe (or the abort cycle) by one cycle.
module tb_nonce_dispatcher;

  localparam int unsigned P = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         job_valid_i;
  logic         job_ready_o;
  logic [255:0] job_midstate_i;
  logic [31:0]  job_merkle_i;
  logic [31:0]  job_time_i;
  logic [31:0]  job_bits_i;
  logic [31:0]  job_nstart_i;
  logic [31:0]  job_nend_i;
  logic         abort_i;
  logic         en_o;
  logic [31:0]  nonce_o;
  logic [511:0] w_in_o;
  logic [255:0] hin_o;
  logic         busy_o;
  logic         done_o;
  logic         aborted_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] t_ns[$];
  logic [31:0] t_ne[$];
  int          t_ab[$];

  nonce_dispatcher #(
    .WORD_S       (32),
    .ISSUE_PERIOD (P)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .job_valid_i    (job_valid_i),
    .job_ready_o    (job_ready_o),
    .job_midstate_i (job_midstate_i),
    .job_merkle_i   (job_merkle_i),
    .job_time_i     (job_time_i),
    .job_bits_i     (job_bits_i),
    .job_nstart_i   (job_nstart_i),
    .job_nend_i     (job_nend_i),
    .abort_i        (abort_i),
    .en_o           (en_o),
    .nonce_o        (nonce_o),
    .w_in_o         (w_in_o),
    .hin_o          (hin_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .aborted_o      (aborted_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [511:0] exp_w(input logic [31:0] m, input logic [31:0] t,
                                         input logic [31:0] b, input logic [31:0] n);
    logic [511:0] w;
    w          = '0;
    w[31:0]    = m;
    w[63:32]   = t;
    w[95:64]   = b;
    w[127:96]  = n;
    w[159:128] = 32'h8000_0000;
    w[511:480] = 32'h0000_0280;
    return w;
  endfunction

  // Offset of the last cycle in which a strobe may occur: the abort cycle if
  // aborted (ab >= 0), else the strobe of the final nonce.
  function automatic int job_end(input logic [31:0] ns, input logic [31:0] ne, input int ab);
    logic [32:0] cnt;
    cnt = {1'b0, ne - ns} + 33'd1;
    if (ab >= 0) return ab;
    return int'(cnt - 33'd1) * int'(P);
  endfunction

  function automatic void model(input int c, input logic [31:0] ns, input logic [31:0] ne,
                                input int ab, output logic e_en, output logic e_done,
                                output logic e_abt, output logic e_busy, output logic e_rdy,
                                output logic [31:0] e_nonce);
    int end_c;
    end_c   = job_end(ns, ne, ab);
    e_en    = (c <= end_c) && ((c % int'(P)) == 0);
    e_done  = (c == end_c + 1);
    e_abt   = (c == end_c + 1) && (ab >= 0);
    e_busy  = (c <= end_c + 1);
    e_rdy   = (c >= end_c + 2);
    e_nonce = ns + 32'(((c < end_c) ? c : end_c) / int'(P));
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset       = 1'b1;
    job_valid_i = 1'b0;
    abort_i     = 1'b0;
    job_midstate_i = '0;
    job_merkle_i = '0;
    job_time_i   = '0;
    job_bits_i   = '0;
    job_nstart_i = '0;
    job_nend_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (job_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_in_reset got %b exp 0", job_ready_o);
    end
    checks++;
    if ({en_o, busy_o, done_o, aborted_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000", {en_o, busy_o, done_o, aborted_o});
    end
    checks++;
    if (nonce_o !== 32'h0 || w_in_o !== 512'h0 || hin_o !== 256'h0) begin
      errors++;
      $display("FAIL reset_data got nonce %h w %h hin %h exp all zero", nonce_o, w_in_o, hin_o);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (job_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after got %b exp 1", job_ready_o);
    end
  endtask

  task automatic test_idle_abort();
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({done_o, busy_o, en_o, job_ready_o} !== 4'b0001) begin
        errors++;
        $display("FAIL idle_abort c=%0d got done/busy/en/ready %b exp 0001", c,
                 {done_o, busy_o, en_o, job_ready_o});
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_jobs();
    for (int j = 0; j < t_ns.size(); j++) begin
      logic [31:0]  ns, ne, m, tm, bt, e_nonce;
      logic [255:0] ms;
      logic         e_en, e_done, e_abt, e_busy, e_rdy;
      int           ab, end_c, k;
      ns = t_ns[j];
      ne = t_ne[j];
      ab = t_ab[j];
      m  = $urandom;
      tm = $urandom;
      bt = $urandom;
      ms = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end_c = job_end(ns, ne, ab);

      k = 0;
      while (job_ready_o !== 1'b1 && k < 300) begin
        @(posedge clk);
        #1;
        k++;
      end
      checks++;
      if (job_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL job%0d ready_wait got %b exp 1", j, job_ready_o);
      end

      job_midstate_i = ms;
      job_merkle_i   = m;
      job_time_i     = tm;
      job_bits_i     = bt;
      job_nstart_i   = ns;
      job_nend_i     = ne;
      job_valid_i    = 1'b1;
      @(posedge clk);
      #1;
      job_valid_i = 1'b0;

      for (int c = 0; c <= end_c + 2; c++) begin
        model(c, ns, ne, ab, e_en, e_done, e_abt, e_busy, e_rdy, e_nonce);
        checks++;
        if (en_o !== e_en) begin
          errors++;
          $display("FAIL job%0d c=%0d en got %b exp %b", j, c, en_o, e_en);
        end
        checks++;
        if (done_o !== e_done || aborted_o !== e_abt) begin
          errors++;
          $display("FAIL job%0d c=%0d done/aborted got %b%b exp %b%b", j, c, done_o, aborted_o,
                   e_done, e_abt);
        end
        checks++;
        if (busy_o !== e_busy || job_ready_o !== e_rdy) begin
          errors++;
          $display("FAIL job%0d c=%0d busy/ready got %b%b exp %b%b", j, c, busy_o, job_ready_o,
                   e_busy, e_rdy);
        end
        checks++;
        if (nonce_o !== e_nonce) begin
          errors++;
          $display("FAIL job%0d c=%0d nonce got %h exp %h", j, c, nonce_o, e_nonce);
        end
        checks++;
        if (w_in_o !== exp_w(m, tm, bt, e_nonce)) begin
          errors++;
          $display("FAIL job%0d c=%0d w_in got %h exp %h", j, c, w_in_o,
                   exp_w(m, tm, bt, e_nonce));
        end
        checks++;
        if (hin_o !== ms) begin
          errors++;
          $display("FAIL job%0d c=%0d hin got %h exp %h", j, c, hin_o, ms);
        end
        abort_i = (c == ab);
        @(posedge clk);
        #1;
      end
      abort_i = 1'b0;
    end
  endtask

  task automatic test_reset_mid_job();
    job_midstate_i = {8{32'hA5A5_0001}};
    job_merkle_i   = 32'h1111_1111;
    job_time_i     = 32'h2222_2222;
    job_bits_i     = 32'h3333_3333;
    job_nstart_i   = 32'd20;
    job_nend_i     = 32'd25;
    job_valid_i    = 1'b1;
    @(posedge clk);
    #1;
    job_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b1 || en_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid pre busy/en got %b%b exp 10", busy_o, en_o);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({en_o, busy_o, done_o, aborted_o, job_ready_o} !== 5'b00000) begin
      errors++;
      $display("FAIL rst_mid flags got %b exp 00000",
               {en_o, busy_o, done_o, aborted_o, job_ready_o});
    end
    checks++;
    if (w_in_o !== 512'h0 || hin_o !== 256'h0 || nonce_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid data got w %h hin %h nonce %h exp zero", w_in_o, hin_o, nonce_o);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done_o !== 1'b0 || job_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid post c=%0d done/ready got %b%b exp 01", c, done_o, job_ready_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] ms_a, ms_b;
    ms_a = {8{32'hAAAA_0000}} ^ {$urandom, $urandom, $urandom, $urandom, 128'h0};
    ms_b = ~ms_a;
    job_midstate_i = ms_a;
    job_nstart_i   = 32'd50;
    job_nend_i     = 32'd51;
    job_valid_i    = 1'b1;
    @(posedge clk);
    #1;
    // job_valid stays high with a different job while the first one runs
    job_midstate_i = ms_b;
    job_nstart_i   = 32'd500;
    job_nend_i     = 32'd500;
    for (int c = 0; c <= int'(P) + 1; c++) begin
      checks++;
      if (hin_o !== ms_a || job_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL b2b c=%0d hin %h ready %b exp hin %h ready 0", c, hin_o, job_ready_o, ms_a);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (job_ready_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b ready_after_done got ready %b done %b exp 1 0", job_ready_o, done_o);
    end
    @(posedge clk);
    #1;
    job_valid_i = 1'b0;
    checks++;
    if (en_o !== 1'b1 || nonce_o !== 32'd500 || hin_o !== ms_b) begin
      errors++;
      $display("FAIL b2b second_job got en %b nonce %h hin %h exp 1 000001f4 %h", en_o, nonce_o,
               hin_o, ms_b);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_o !== 1'b1 || aborted_o !== 1'b0 || en_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b second_done got done %b aborted %b en %b exp 1 0 0", done_o, aborted_o,
               en_o);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Directed: single, 5-nonce range, wrap, abort in WAIT after 2nd strobe,
    // abort coinciding with the 2nd strobe.
    t_ns.push_back(32'h0000_1234); t_ne.push_back(32'h0000_1234); t_ab.push_back(-1);
    t_ns.push_back(32'd10);        t_ne.push_back(32'd14);        t_ab.push_back(-1);
    t_ns.push_back(32'hFFFF_FFFE); t_ne.push_back(32'h0000_0001); t_ab.push_back(-1);
    t_ns.push_back(32'd100);       t_ne.push_back(32'd105);       t_ab.push_back(int'(P) + 5);
    t_ns.push_back(32'd7);         t_ne.push_back(32'd9);         t_ab.push_back(int'(P));
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ns;
      int          cnt, ab;
      ns  = (i == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
      cnt = int'($urandom_range(1, 4));
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, (cnt - 1) * P)) : -1;
      t_ns.push_back(ns);
      t_ne.push_back(ns + 32'(cnt - 1));
      t_ab.push_back(ab);
    end

    test_reset();
    test_idle_abort();
    test_jobs();
    test_reset_mid_job();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
